// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N-to-1 arbitrating mux.
package arb_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic logic [31:0] next_rr_idx(input logic [31:0] idx, input int unsigned n);
    return (idx >= 32'(n - 1)) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter: combinational one-hot grant, owns the RR pointer.
// Grant is gated by en; the pointer advances only on upd (an actual transfer).
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int        NUM_CH   = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] cand,
  input  logic              en,
  input  logic              upd,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] cur;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cur       = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (cand[i]) begin
          grant_idx = CH_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Scan starts one past the last winner and wraps, so the last winner is checked last.
      cur = CH_W'(next_rr_idx(32'(last_q), NUM_CH));
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_vld && cand[cur]) begin
          grant_idx = cur;
          grant_vld = 1'b1;
        end
        cur = CH_W'(next_rr_idx(32'(cur), NUM_CH));
      end
    end
  end

  always_comb begin
    grant = '0;
    if (en && grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CH_W'(NUM_CH - 1);
    end else if (upd) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-to-1 valid/ready mux with RR or fixed arbitration and forced select; 1-cycle latency.
// Single-entry output register refills on the drain edge; inputs stall while output is held.
module arb_mux_nx1
  import arb_mux_pkg::*;
#(
  parameter int        NUM_CH   = 4,
  parameter int        DATA_W   = 8,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  input  logic                     force_i,
  input  logic [CH_W-1:0]          sel_i,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  input  logic                     out_ready_i
);

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              can_load;
  logic              xfer;

  assign can_load = !out_valid_o || out_ready_i;

  always_comb begin
    cand = '0;
    if (force_i) begin
      if (32'(sel_i) < NUM_CH) cand[sel_i] = in_valid_i[sel_i];
    end else begin
      cand = in_valid_i;
    end
  end

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .cand      (cand),
    .en        (can_load),
    .upd       (xfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Ready must stay low for the whole reset, not just until the first edge.
  assign in_ready_o = grant & {NUM_CH{rst_ni}};
  assign xfer       = grant_vld && |(in_valid_i & in_ready_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= in_data_i[grant_idx*DATA_W +: DATA_W];
      out_ch_o    <= grant_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Directed bench for arb_mux_nx1: vector table for RR/forced sequences plus hand-written corner cases.
module tb_arb_mux_nx1;
  import arb_mux_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        frc;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fx_in_ready;
  logic        rr_out_valid, fx_out_valid;
  logic [7:0]  rr_out_data, fx_out_data;
  logic [1:0]  rr_out_ch, fx_out_ch;

  int tests;
  int fails;

  arb_mux_nx1 #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(ARB_RR)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rr_in_ready), .force_i(frc), .sel_i(sel), .out_valid_o(rr_out_valid),
    .out_data_o(rr_out_data), .out_ch_o(rr_out_ch), .out_ready_i(out_ready)
  );

  arb_mux_nx1 #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(fx_in_ready), .force_i(frc), .sel_i(sel), .out_valid_o(fx_out_valid),
    .out_data_o(fx_out_data), .out_ch_o(fx_out_ch), .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        frc;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_dat;
    logic [1:0]  exp_ch;
  } vec_t;

  localparam logic [31:0] D  = 32'hA3A2A1A0;
  localparam logic [31:0] DF = 32'h3FA2A1A0;
  localparam logic [31:0] DB = 32'hA35CA1A0;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic f,
                       input logic [1:0] s, input logic r);
    in_valid  = v;
    in_data   = d;
    frc       = f;
    sel       = s;
    out_ready = r;
  endtask

  task automatic chk_rr_out(input string name, input logic ov, input logic [7:0] dat,
                            input logic [1:0] ch);
    chk({name, ".valid"}, 32'(rr_out_valid), 32'(ov));
    chk({name, ".data"},  32'(rr_out_data),  32'(dat));
    chk({name, ".ch"},    32'(rr_out_ch),    32'(ch));
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //           valid    data frc sel  ordy rdy      ov    dat    ch
    vecs[0]  = '{4'b1111, D,  0, 2'd0, 1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[1]  = '{4'b1111, D,  0, 2'd0, 1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[2]  = '{4'b1111, D,  0, 2'd0, 1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[3]  = '{4'b1111, D,  0, 2'd0, 1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[4]  = '{4'b1111, D,  0, 2'd0, 1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[5]  = '{4'b0000, D,  0, 2'd0, 1, 4'b0000, 1'b0, 8'hA0, 2'd0};
    vecs[6]  = '{4'b0100, D,  0, 2'd0, 0, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[7]  = '{4'b1111, D,  0, 2'd0, 0, 4'b0000, 1'b1, 8'hA2, 2'd2};
    vecs[8]  = '{4'b1111, D,  0, 2'd0, 1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[9]  = '{4'b0000, D,  0, 2'd0, 1, 4'b0000, 1'b0, 8'hA3, 2'd3};
    vecs[10] = '{4'b1111, DF, 1, 2'd3, 1, 4'b1000, 1'b1, 8'h3F, 2'd3};
    vecs[11] = '{4'b0111, DF, 1, 2'd3, 1, 4'b0000, 1'b0, 8'h3F, 2'd3};
    vecs[12] = '{4'b0010, D,  1, 2'd1, 1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[13] = '{4'b1111, D,  0, 2'd0, 1, 4'b0100, 1'b1, 8'hA2, 2'd2};

    // Reset held with all channels requesting
    rst_n = 1'b0;
    drive(4'b1111, D, 1'b0, 2'd0, 1'b1);
    #12;
    chk("rst.rr_ready", 32'(rr_in_ready), 32'h0);
    chk("rst.fx_ready", 32'(fx_in_ready), 32'h0);
    chk_rr_out("rst", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].frc, vecs[i].sel, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(rr_in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk_rr_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_dat, vecs[i].exp_ch);
    end

    // Fixed priority: ch1 beats ch3 every cycle
    drive(4'b1010, D, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fix%0d.ready", i), 32'(fx_in_ready), 32'b0010);
      tick();
      chk($sformatf("fix%0d.ch", i), 32'(fx_out_ch), 32'd1);
      chk($sformatf("fix%0d.data", i), 32'(fx_out_data), 32'hA1);
    end

    // Backpressure: load 5C from ch2, hold 3 cycles, then drain+refill on one edge
    drive(4'b0000, DB, 1'b0, 2'd0, 1'b1);
    tick();
    drive(4'b0100, DB, 1'b0, 2'd0, 1'b1);
    tick();
    chk_rr_out("bp.load", 1'b1, 8'h5C, 2'd2);
    drive(4'b1111, DB, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.ready", i), 32'(rr_in_ready), 32'h0);
      tick();
      chk_rr_out($sformatf("bp%0d", i), 1'b1, 8'h5C, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.refill_ready", 32'(rr_in_ready), 32'b1000);
    tick();
    chk_rr_out("bp.refill", 1'b1, 8'hA3, 2'd3);

    // Move pointer to ch0 so a post-reset grant to ch0 proves the pointer restarted
    drive(4'b0001, D, 1'b0, 2'd0, 1'b1);
    tick();
    chk_rr_out("pre_rst", 1'b1, 8'hA0, 2'd0);
    drive(4'b1111, D, 1'b0, 2'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rr_out("mid_rst", 1'b0, 8'h00, 2'd0);
    chk("mid_rst.ready", 32'(rr_in_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_rr_out("post_rst", 1'b1, 8'hA0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
